// File: rtl/cfu_pkg.sv
// cfu_pkg
//   Shared CFU-L2 definitions: default field widths, the response status
//   codes and the parameter check used by cfu_l2_arbiter.
//   No ports (package).
package cfu_pkg;

  // CFU-L2 interface version and default field widths
  localparam int CFU_LI_VERSION      = 1;
  localparam int CFU_CFU_ID_W_DEF    = 4;
  localparam int CFU_STATE_ID_W_DEF  = 3;
  localparam int CFU_FUNC_ID_W_DEF   = 10;
  localparam int CFU_INSN_W_DEF      = 32;
  localparam int CFU_DATA_W_DEF      = 32;
  localparam int CFU_STATUS_W_DEF    = 3;

  // Response status codes carried on *_resp_status
  typedef enum logic [CFU_STATUS_W_DEF-1:0] {
    CFU_OK           = 3'd0,
    CFU_ERROR_CFU    = 3'd1,
    CFU_ERROR_STATE  = 3'd2,
    CFU_ERROR_FUNC   = 3'd3,
    CFU_ERROR_INSN   = 3'd4,
    CFU_ERROR_CUSTOM = 3'd7
  } cfu_status_e;

  // Largest number of upstream requesters one arbiter may serve
  localparam int CFU_ARB_MAX_REQ = 16;

  // Returns 1 when the arbiter parameters are usable: 2..CFU_ARB_MAX_REQ
  // requesters, and a tag FIFO depth that is a power of two of at least 2.
  function automatic bit check_cfu_arb_params(input int n_req, input int depth);
    bit ok;
    ok = 1'b1;
    if (n_req < 2 || n_req > CFU_ARB_MAX_REQ) ok = 1'b0;
    if (depth < 2) ok = 1'b0;
    if ((depth & (depth - 1)) != 0) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/cfu_tag_fifo.sv
// cfu_tag_fifo
//   Synchronous in-order FIFO holding the requester index of every request
//   that has been granted but not yet answered. Full/empty come from an
//   occupancy counter, so all DEPTH entries are usable.
// Ports
//   clk        clock
//   rst        synchronous reset, active low (empties the FIFO)
//   clk_en     state advances only when 1
//   push       write push_data at the tail (ignored when full)
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   head_data  current head entry, valid only when empty==0
//   full       DEPTH entries held
//   empty      no entries held
module cfu_tag_fifo
  import cfu_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PTR_W + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = clk_en & push & ~full;
  assign do_pop    = clk_en & pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
  // push and pop moves both pointers and leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cfu_l2_arbiter.sv
// cfu_l2_arbiter
//   Shares one downstream CFU-L2 port among N_REQ upstream requesters.
//   Requests are granted round-robin with no added latency; the granted
//   index is queued in an in-order tag FIFO and each downstream response
//   is steered back to the requester at the FIFO head.
// Ports
//   clk, rst, clk_en           clock, synchronous active-low reset, enable
//   up_req_valid/ready         per-requester request handshake
//   up_req_cfu..up_req_data1   flattened request fields, requester i at [i*w +: w]
//   up_resp_valid/ready        per-requester response handshake
//   up_resp_status/data        response fields, broadcast to all requesters
//   dn_req_*                   request port toward the shared CFU
//   dn_resp_*                  response port from the shared CFU
//   resp_error                 response offered while nothing is outstanding
module cfu_l2_arbiter
  import cfu_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DEPTH          = 4,
  parameter int CFU_CFU_ID_W   = CFU_CFU_ID_W_DEF,
  parameter int CFU_STATE_ID_W = CFU_STATE_ID_W_DEF,
  parameter int CFU_FUNC_ID_W  = CFU_FUNC_ID_W_DEF,
  parameter int CFU_INSN_W     = CFU_INSN_W_DEF,
  parameter int CFU_DATA_W     = CFU_DATA_W_DEF,
  parameter int CFU_STATUS_W   = CFU_STATUS_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic [N_REQ-1:0]            up_req_valid,
  output logic [N_REQ-1:0]            up_req_ready,
  input  logic [N_REQ*CFU_CFU_ID_W-1:0]   up_req_cfu,
  input  logic [N_REQ*CFU_STATE_ID_W-1:0] up_req_state,
  input  logic [N_REQ*CFU_FUNC_ID_W-1:0]  up_req_func,
  input  logic [N_REQ*CFU_INSN_W-1:0]     up_req_insn,
  input  logic [N_REQ*CFU_DATA_W-1:0]     up_req_data0,
  input  logic [N_REQ*CFU_DATA_W-1:0]     up_req_data1,
  output logic [N_REQ-1:0]            up_resp_valid,
  input  logic [N_REQ-1:0]            up_resp_ready,
  output logic [CFU_STATUS_W-1:0]     up_resp_status,
  output logic [CFU_DATA_W-1:0]       up_resp_data,
  output logic                        dn_req_valid,
  input  logic                        dn_req_ready,
  output logic [CFU_CFU_ID_W-1:0]     dn_req_cfu,
  output logic [CFU_STATE_ID_W-1:0]   dn_req_state,
  output logic [CFU_FUNC_ID_W-1:0]    dn_req_func,
  output logic [CFU_INSN_W-1:0]       dn_req_insn,
  output logic [CFU_DATA_W-1:0]       dn_req_data0,
  output logic [CFU_DATA_W-1:0]       dn_req_data1,
  input  logic                        dn_resp_valid,
  output logic                        dn_resp_ready,
  input  logic [CFU_STATUS_W-1:0]     dn_resp_status,
  input  logic [CFU_DATA_W-1:0]       dn_resp_data,
  output logic                        resp_error
);

  localparam int IDX_W = $clog2(N_REQ);

  if (!check_cfu_arb_params(N_REQ, DEPTH)) begin : g_bad_params
    $error("cfu_l2_arbiter: N_REQ or DEPTH out of range");
  end

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] head_idx;
  logic             any_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             req_fire;
  logic             resp_fire;
  int               grant_base;

  // Rotating priority encoder: scan requesters starting at rr_ptr and take
  // the first one asserting valid. With no valid requester grant_idx is a
  // don't-care because dn_req_valid is low.
  always_comb begin
    int  cand;
    logic found;
    grant_idx = rr_ptr;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && up_req_valid[cand]) begin
        grant_idx = cand[IDX_W-1:0];
        found     = 1'b1;
      end
    end
  end

  assign any_valid    = |up_req_valid;
  // A full FIFO blocks new grants even if a pop fires in the same cycle.
  assign dn_req_valid = rst & any_valid & ~fifo_full;
  assign req_fire     = dn_req_valid & dn_req_ready & clk_en;
  assign next_ptr     = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Only the granted requester sees ready, and only when the downstream
  // port can take the request this cycle.
  always_comb begin
    up_req_ready = '0;
    if (dn_req_valid && dn_req_ready) begin
      up_req_ready[grant_idx] = 1'b1;
    end
  end

  // Request fields come straight from the granted requester (no registers).
  assign grant_base   = int'(grant_idx);
  assign dn_req_cfu   = up_req_cfu  [grant_base*CFU_CFU_ID_W   +: CFU_CFU_ID_W];
  assign dn_req_state = up_req_state[grant_base*CFU_STATE_ID_W +: CFU_STATE_ID_W];
  assign dn_req_func  = up_req_func [grant_base*CFU_FUNC_ID_W  +: CFU_FUNC_ID_W];
  assign dn_req_insn  = up_req_insn [grant_base*CFU_INSN_W     +: CFU_INSN_W];
  assign dn_req_data0 = up_req_data0[grant_base*CFU_DATA_W     +: CFU_DATA_W];
  assign dn_req_data1 = up_req_data1[grant_base*CFU_DATA_W     +: CFU_DATA_W];

  // Round-robin pointer moves past the winner only on an accepted request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (req_fire) begin
      rr_ptr <= next_ptr;
    end
  end

  cfu_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .push      (req_fire),
    .push_data (grant_idx),
    .pop       (resp_fire),
    .head_data (head_idx),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Responses go to the oldest outstanding requester. A response with no
  // outstanding tag is never accepted and is flagged on resp_error.
  always_comb begin
    up_resp_valid = '0;
    if (rst && dn_resp_valid && !fifo_empty) begin
      up_resp_valid[head_idx] = 1'b1;
    end
  end

  assign dn_resp_ready  = rst & ~fifo_empty & up_resp_ready[head_idx];
  assign resp_fire      = dn_resp_valid & dn_resp_ready & clk_en;
  assign resp_error     = rst & dn_resp_valid & fifo_empty;
  assign up_resp_status = dn_resp_status;
  assign up_resp_data   = dn_resp_data;

endmodule

// File: tb/tb_cfu_l2_arbiter.sv
// tb_cfu_l2_arbiter
//   Directed bench for cfu_l2_arbiter (N_REQ=4, DEPTH=4). A queue-based
//   model of round-robin grant and in-order return predicts every output
//   each cycle; a small 1-cycle echo CFU (data0+data1) can serve requests.
module tb_cfu_l2_arbiter;
  import cfu_pkg::*;

  localparam int N_REQ = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic [N_REQ-1:0] up_req_valid;
  logic [N_REQ-1:0] up_req_ready;
  logic [N_REQ*4-1:0]  up_req_cfu;
  logic [N_REQ*3-1:0]  up_req_state;
  logic [N_REQ*10-1:0] up_req_func;
  logic [N_REQ*32-1:0] up_req_insn;
  logic [N_REQ*32-1:0] up_req_data0;
  logic [N_REQ*32-1:0] up_req_data1;
  logic [N_REQ-1:0] up_resp_valid;
  logic [N_REQ-1:0] up_resp_ready;
  logic [2:0]  up_resp_status;
  logic [31:0] up_resp_data;
  logic        dn_req_valid;
  logic        dn_req_ready;
  logic [3:0]  dn_req_cfu;
  logic [2:0]  dn_req_state;
  logic [9:0]  dn_req_func;
  logic [31:0] dn_req_insn;
  logic [31:0] dn_req_data0;
  logic [31:0] dn_req_data1;
  logic        dn_resp_valid;
  logic        dn_resp_ready;
  logic [2:0]  dn_resp_status;
  logic [31:0] dn_resp_data;
  logic        resp_error;

  // Per-requester request fields
  logic [3:0]  cfu_f   [N_REQ];
  logic [2:0]  state_f [N_REQ];
  logic [9:0]  func_f  [N_REQ];
  logic [31:0] insn_f  [N_REQ];
  logic [31:0] d0_f    [N_REQ];
  logic [31:0] d1_f    [N_REQ];

  // Downstream response source: echo CFU or manual drive
  logic        cfu_auto;
  logic        man_valid;
  logic [2:0]  man_status;
  logic [31:0] man_data;
  logic        stub_valid = 1'b0;
  logic [31:0] stub_data = '0;
  logic [31:0] stub_q [$];

  // Model state
  int          m_ptr;
  int          m_q   [$];
  logic [31:0] m_dq  [$];
  int          grant_log [$];
  int          resp_log  [$];
  logic [31:0] resp_dlog [$];

  int  n_checks = 0;
  int  n_fail   = 0;
  logic check_en = 1'b0;

  assign dn_resp_valid  = cfu_auto ? stub_valid : man_valid;
  assign dn_resp_data   = cfu_auto ? stub_data  : man_data;
  assign dn_resp_status = cfu_auto ? 3'(CFU_OK) : man_status;

  always #5 clk = ~clk;

  // Pack the per-requester field arrays into the flattened ports.
  always_comb begin
    up_req_cfu = '0; up_req_state = '0; up_req_func = '0;
    up_req_insn = '0; up_req_data0 = '0; up_req_data1 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      up_req_cfu  [i*4  +: 4]  = cfu_f[i];
      up_req_state[i*3  +: 3]  = state_f[i];
      up_req_func [i*10 +: 10] = func_f[i];
      up_req_insn [i*32 +: 32] = insn_f[i];
      up_req_data0[i*32 +: 32] = d0_f[i];
      up_req_data1[i*32 +: 32] = d1_f[i];
    end
  end

  cfu_l2_arbiter #(
    .N_REQ (N_REQ),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst (rst), .clk_en (clk_en),
    .up_req_valid (up_req_valid), .up_req_ready (up_req_ready),
    .up_req_cfu (up_req_cfu), .up_req_state (up_req_state),
    .up_req_func (up_req_func), .up_req_insn (up_req_insn),
    .up_req_data0 (up_req_data0), .up_req_data1 (up_req_data1),
    .up_resp_valid (up_resp_valid), .up_resp_ready (up_resp_ready),
    .up_resp_status (up_resp_status), .up_resp_data (up_resp_data),
    .dn_req_valid (dn_req_valid), .dn_req_ready (dn_req_ready),
    .dn_req_cfu (dn_req_cfu), .dn_req_state (dn_req_state),
    .dn_req_func (dn_req_func), .dn_req_insn (dn_req_insn),
    .dn_req_data0 (dn_req_data0), .dn_req_data1 (dn_req_data1),
    .dn_resp_valid (dn_resp_valid), .dn_resp_ready (dn_resp_ready),
    .dn_resp_status (dn_resp_status), .dn_resp_data (dn_resp_data),
    .resp_error (resp_error)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // First requester at or after ptr (cyclically) with valid set.
  function automatic int rr_pick(input int ptr, input logic [N_REQ-1:0] v);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return 0;
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return 99;
  endfunction

  function automatic int log_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : 99;
  endfunction

  // Drive the request valids and let the given number of clock edges pass.
  task automatic apply_stimulus(input logic [N_REQ-1:0] valid, input int cycles);
    up_req_valid = valid;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // 1-cycle echo CFU: answers each accepted request with data0+data1.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      stub_q.delete();
    end else if (cfu_auto && clk_en) begin
      if (dn_resp_valid && dn_resp_ready) void'(stub_q.pop_front());
      if (dn_req_valid && dn_req_ready) stub_q.push_back(dn_req_data0 + dn_req_data1);
    end
    stub_valid <= (stub_q.size() != 0);
    stub_data  <= (stub_q.size() != 0) ? stub_q[0] : 32'h0;
  end

  // Model update: round-robin grant into an in-order queue of outstanding
  // requesters, popped by accepted responses. Also logs what the DUT did.
  initial forever begin
    int  g;
    int  head;
    bit  full_m;
    bit  empty_m;
    bit  push_m;
    bit  pop_m;
    @(posedge clk);
    if (rst && clk_en && dn_req_valid && dn_req_ready)
      grant_log.push_back(onehot_idx(up_req_ready));
    if (rst && clk_en && |(up_resp_valid & up_resp_ready)) begin
      resp_log.push_back(onehot_idx(up_resp_valid));
      resp_dlog.push_back(up_resp_data);
    end
    if (!rst) begin
      m_ptr = 0;
      m_q.delete();
      m_dq.delete();
    end else if (clk_en) begin
      full_m  = (m_q.size() == DEPTH);
      empty_m = (m_q.size() == 0);
      head    = empty_m ? 0 : m_q[0];
      g       = rr_pick(m_ptr, up_req_valid);
      push_m  = (|up_req_valid) && !full_m && dn_req_ready;
      pop_m   = !empty_m && dn_resp_valid && up_resp_ready[head];
      if (pop_m) begin
        void'(m_q.pop_front());
        void'(m_dq.pop_front());
      end
      if (push_m) begin
        m_q.push_back(g);
        m_dq.push_back(d0_f[g] + d1_f[g]);
        m_ptr = (g + 1) % N_REQ;
      end
    end
  end

  // Every-cycle comparison of the DUT outputs against the model.
  initial forever begin
    int g;
    int head;
    bit full_m;
    bit empty_m;
    bit e_dnv;
    logic [N_REQ-1:0] e_rr;
    logic [N_REQ-1:0] e_rv;
    @(negedge clk);
    if (check_en) begin
      full_m  = (m_q.size() == DEPTH);
      empty_m = (m_q.size() == 0);
      head    = empty_m ? 0 : m_q[0];
      g       = rr_pick(m_ptr, up_req_valid);
      e_dnv   = rst && (|up_req_valid) && !full_m;
      e_rr    = (e_dnv && dn_req_ready) ? N_REQ'(1 << g) : '0;
      e_rv    = (rst && dn_resp_valid && !empty_m) ? N_REQ'(1 << head) : '0;
      check_output("dn_req_valid", 64'(dn_req_valid), 64'(e_dnv));
      check_output("up_req_ready", 64'(up_req_ready), 64'(e_rr));
      check_output("up_resp_valid", 64'(up_resp_valid), 64'(e_rv));
      check_output("dn_resp_ready", 64'(dn_resp_ready),
                   64'(rst && !empty_m && up_resp_ready[head]));
      check_output("resp_error", 64'(resp_error), 64'(rst && dn_resp_valid && empty_m));
      if (e_dnv) begin
        check_output("dn_req_cfu", 64'(dn_req_cfu), 64'(cfu_f[g]));
        check_output("dn_req_state", 64'(dn_req_state), 64'(state_f[g]));
        check_output("dn_req_func", 64'(dn_req_func), 64'(func_f[g]));
        check_output("dn_req_insn", 64'(dn_req_insn), 64'(insn_f[g]));
        check_output("dn_req_data0", 64'(dn_req_data0), 64'(d0_f[g]));
        check_output("dn_req_data1", 64'(dn_req_data1), 64'(d1_f[g]));
      end
      if (e_rv != '0) begin
        check_output("up_resp_status", 64'(up_resp_status),
                     cfu_auto ? 64'(CFU_OK) : 64'(man_status));
        check_output("up_resp_data", 64'(up_resp_data),
                     cfu_auto ? 64'(m_dq[0]) : 64'(man_data));
      end
    end
  end

  // Directed scenarios with literal expectations.
  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      cfu_f[i]   = 4'(i + 1);
      state_f[i] = 3'(i);
      func_f[i]  = 10'(32'h30 + i);
      insn_f[i]  = 32'hA000_0000 + 32'(i);
      d0_f[i]    = 32'h100 * 32'(i + 1);
      d1_f[i]    = 32'(i + 1);
    end
    rst = 1'b0; clk_en = 1'b1; up_req_valid = '1; up_resp_ready = '1;
    dn_req_ready = 1'b1; cfu_auto = 1'b1;
    man_valid = 1'b0; man_status = 3'(CFU_OK); man_data = '0;
    check_en = 1'b1;

    // Reset held with every requester valid
    @(negedge clk);
    check_output("reset_up_req_ready", 64'(up_req_ready), 64'h0);
    check_output("reset_dn_req_valid", 64'(dn_req_valid), 64'h0);
    apply_stimulus(4'hF, 3);
    rst = 1'b1;
    @(negedge clk);
    check_output("first_grant", 64'(up_req_ready), 64'h1);
    #1;

    // Fairness with the echo CFU
    apply_stimulus(4'hF, 8);
    apply_stimulus(4'h0, 2);
    for (int i = 0; i < 5; i++)
      check_output($sformatf("fair_grant%0d", i), 64'(log_at(grant_log, i)), 64'(i % 4));
    check_output("fair_resp0_idx", 64'(log_at(resp_log, 0)), 64'd0);
    check_output("fair_resp0_data", 64'((resp_dlog.size() > 0) ? resp_dlog[0] : 32'hX), 64'h101);
    check_output("fair_resp1_idx", 64'(log_at(resp_log, 1)), 64'd1);
    check_output("fair_resp1_data", 64'((resp_dlog.size() > 1) ? resp_dlog[1] : 32'hX), 64'h202);

    // Skip: move the pointer to 2, then only 1 and 3 request
    apply_stimulus(4'b0010, 1);
    apply_stimulus(4'b0000, 2);
    grant_log.delete();
    apply_stimulus(4'b1010, 3);
    apply_stimulus(4'b0000, 2);
    check_output("skip_grant0", 64'(log_at(grant_log, 0)), 64'd3);
    check_output("skip_grant1", 64'(log_at(grant_log, 1)), 64'd1);
    check_output("skip_grant2", 64'(log_at(grant_log, 2)), 64'd3);

    // Full: four requests with no responses
    cfu_auto = 1'b0;
    apply_stimulus(4'hF, 4);
    @(negedge clk);
    check_output("full_dn_req_valid", 64'(dn_req_valid), 64'h0);
    check_output("full_up_req_ready", 64'(up_req_ready), 64'h0);
    @(posedge clk); #1;
    man_valid = 1'b1; man_data = 32'h1111;
    @(negedge clk);
    check_output("full_no_bypass", 64'(dn_req_valid), 64'h0);
    check_output("full_pop_ready", 64'(dn_resp_ready), 64'h1);
    @(posedge clk); #1;
    man_valid = 1'b0;
    @(negedge clk);
    check_output("full_regrant_valid", 64'(dn_req_valid), 64'h1);
    check_output("full_regrant_ready", 64'(up_req_ready), 64'h1);
    #1 up_req_valid = '0;

    // Response backpressure from the head requester (index 1)
    @(posedge clk); #1;
    man_valid = 1'b1; man_data = 32'hCAFE_0005; up_resp_ready = 4'b1101;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_output("bp_dn_resp_ready", 64'(dn_resp_ready), 64'h0);
    check_output("bp_up_resp_valid", 64'(up_resp_valid), 64'b0010);
    check_output("bp_up_resp_data", 64'(up_resp_data), 64'hCAFE_0005);
    @(posedge clk); #1;
    up_resp_ready = '1;
    repeat (3) @(posedge clk);
    #1 man_valid = 1'b0;

    // Protocol error: response with nothing outstanding
    man_valid = 1'b1; man_status = 3'(CFU_ERROR_FUNC); man_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check_output("err_flag", 64'(resp_error), 64'h1);
    check_output("err_dn_resp_ready", 64'(dn_resp_ready), 64'h0);
    check_output("err_up_resp_valid", 64'(up_resp_valid), 64'h0);
    @(posedge clk); #1;
    man_valid = 1'b0; up_req_valid = 4'b0100;
    @(posedge clk); #1;
    up_req_valid = '0; man_valid = 1'b1;
    @(negedge clk);
    check_output("errstat_valid", 64'(up_resp_valid), 64'b0100);
    check_output("errstat_status", 64'(up_resp_status), 64'(CFU_ERROR_FUNC));
    @(posedge clk); #1;
    man_valid = 1'b0; man_status = 3'(CFU_OK);

    // clk_en low freezes the pointer and FIFO
    clk_en = 1'b0;
    apply_stimulus(4'hF, 3);
    clk_en = 1'b1;
    @(negedge clk);
    check_output("clken_hold_grant", 64'(up_req_ready), 64'b1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    up_req_valid = '0;

    // Reset with two requests outstanding discards their tags
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; man_valid = 1'b1;
    @(negedge clk);
    check_output("midreset_error", 64'(resp_error), 64'h1);
    check_output("midreset_resp_valid", 64'(up_resp_valid), 64'h0);
    @(posedge clk); #1;
    man_valid = 1'b0; up_req_valid = '1;
    @(negedge clk);
    check_output("midreset_ptr", 64'(up_req_ready), 64'h1);
    #1 up_req_valid = '0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
